mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
- Moore FSM that sequences the shared multicycle MIPS datapath.
- Drives every 2:1 and 4:1 mux select, register/memory write enable and ALU op class, cycle by cycle, from the instruction opcode.
- Sits beside the datapath; one instance per core.
- Stalls on a single-bit memory-ready handshake so the datapath tolerates multi-cycle memory.

Parameters:
- OPW, 6, opcode field width (instr[31:26]).
- STW, 4, state encoding width (also the width of state_dbg).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  OPW  instr[31:26] taken from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current read/write this cycle.
- iord  output  1  address mux select: 0 = PC, 1 = ALUOut.
- alusrca  output  1  ALU A mux select: 0 = PC, 1 = regA.
- alusrcb  output  2  ALU B mux select: 00 = regB, 01 = const 4, 10 = signimm, 11 = signimm<<2.
- regdst  output  1  write-register mux select: 0 = rt, 1 = rd.
- memtoreg  output  1  write-back mux select: 0 = ALUOut, 1 = MDR.
- pcsrc  output  2  PC mux select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  output  2  00 = add, 01 = sub, 10 = decode by funct.
- irwrite  output  1  instruction register load enable.
- memread  output  1  memory read request.
- memwrite  output  1  memory write request.
- regwrite  output  1  register file write enable.
- pcen  output  1  PC load enable = pcwrite | (branch & zero).
- state_dbg  output  STW  current state, for debug.

Behaviour:
- Reset: asynchronous. State goes to FETCH immediately. While reset=1, irwrite, memwrite, regwrite, pcen and memread are forced to 0. Other selects take their FETCH values.
- Outputs are combinational from state (Moore). The only exceptions are the mem_ready-gated enables listed below and pcen's dependency on zero. All outputs not listed for a state are 0.
- FETCH
  - Outputs: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcen are asserted only in the cycle where mem_ready=1.
  - mem_ready=0: stay in FETCH. mem_ready=1: go to DECODE.
- DECODE
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target).
  - Next state by opcode: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> RTYPEEX; 000100 (beq) -> BRANCH; 001000 (addi) -> ADDIEX; 000010 (j) -> JUMP.
  - Any other opcode -> FETCH. It is treated as a NOP and has no side effects.
- MEMADR
  - Outputs: alusrca=1, alusrcb=10, aluop=00.
  - Next: lw -> MEMRD; sw -> MEMWR.
- MEMRD
  - Outputs: memread=1, iord=1.
  - Holds until mem_ready=1, then goes to MEMWB.
- MEMWB
  - Outputs: regwrite=1, memtoreg=1, regdst=0.
  - Next: FETCH.
- MEMWR
  - Outputs: memwrite=1 and iord=1, both held steady for the whole stall.
  - Holds until mem_ready=1, then goes to FETCH.
- RTYPEEX
  - Outputs: alusrca=1, alusrcb=00, aluop=10.
  - Next: ALUWB.
- ALUWB
  - Outputs: regwrite=1, regdst=1, memtoreg=0.
  - Next: FETCH.
- BRANCH
  - Outputs: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, internal branch=1, so pcen=zero.
  - Next: FETCH.
- ADDIEX
  - Outputs: alusrca=1, alusrcb=10, aluop=00.
  - Next: ADDIWB.
- ADDIWB
  - Outputs: regwrite=1, regdst=0, memtoreg=0.
  - Next: FETCH.
- JUMP
  - Outputs: pcsrc=10, pcen=1.
  - Next: FETCH.
- Unreachable state encodings go to FETCH with all enables 0.
- Invariants:
  - At most one of memread/memwrite is high in any cycle.
  - regwrite is never high in the same cycle as memwrite.
- Latency: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles, each plus any mem_ready stall cycles.
- Reset asserted mid-instruction aborts the instruction. No write enable is asserted afterwards until FETCH completes.

Decomposition:
- Shared package mips_pkg holds:
  - the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - the state enumeration;
  - the ALUOP_*, SRCB_* and PCSRC_* encodings.
- Natural sub-module: mips_ctrl_outdec, a purely combinational state-to-control-vector decoder. The FSM top level keeps the state register, next-state logic and the pcen/mem_ready gating.

Test Plan:
- Reset mid-MEMWR with memwrite high: memwrite drops in the same cycle; after release, state_dbg=FETCH and no write occurs until the next fetch completes.
- lw (opcode 0x23) with mem_ready always 1: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1 and memtoreg=1 only in cycle 5.
- sw (0x2B) with mem_ready held low 3 cycles in MEMWR: memwrite=1 and iord=1 for 4 consecutive cycles, then FETCH; regwrite stays 0 throughout.
- beq (0x04): zero=1 gives pcen=1 and pcsrc=01 in BRANCH; zero=0 gives pcen=0. R-type: aluop=10, then regdst=1 and regwrite=1.
- FETCH with mem_ready low 2 cycles: irwrite=0 and pcen=0 for 2 cycles, then both 1 for exactly 1 cycle.
- Illegal opcode 0x3F: DECODE goes directly to FETCH with no regwrite, memwrite or pcen pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, FSM states and control encodings for the multicycle MIPS controller
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;
  typedef struct packed {
    logic iord;
    logic alusrca;
    logic [1:0] alusrcb;
    logic regdst;
    logic memtoreg;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic irwrite;
    logic memread;
    logic memwrite;
    logic regwrite;
    logic pcwrite;
    logic branch;
  } ctrl_t;
endpackage

// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: controller <-> datapath signal bundle
interface mips_multicycle_control_if #(
  parameter int OPW = 6,
  parameter int STW = 4
);
  logic [OPW-1:0] opcode;
  logic zero;
  logic mem_ready;
  logic iord;
  logic alusrca;
  logic [1:0] alusrcb;
  logic regdst;
  logic memtoreg;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic irwrite;
  logic memread;
  logic memwrite;
  logic regwrite;
  logic pcen;
  logic [STW-1:0] state_dbg;
  modport master (
    input opcode, zero, mem_ready,
    output iord, alusrca, alusrcb, regdst, memtoreg, pcsrc, aluop,
    output irwrite, memread, memwrite, regwrite, pcen, state_dbg
  );
  modport slave (
    output opcode, zero, mem_ready,
    input iord, alusrca, alusrcb, regdst, memtoreg, pcsrc, aluop,
    input irwrite, memread, memwrite, regwrite, pcen, state_dbg
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: purely combinational state-to-control-vector decoder
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input state_t i_state,
  output ctrl_t o_ctrl
);
  // Moore decode; any unlisted or unreachable state leaves every control at 0
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.alusrcb = SRCB_FOUR;
        o_ctrl.aluop = ALUOP_ADD;
        o_ctrl.pcsrc = PCSRC_ALU;
        o_ctrl.irwrite = 1'b1;
        o_ctrl.pcwrite = 1'b1;
      end
      S_DECODE: o_ctrl.alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.memwrite = 1'b1;
        o_ctrl.iord = 1'b1;
      end
      S_RTYPEEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_REGB;
        o_ctrl.aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.aluop = ALUOP_SUB;
        o_ctrl.pcsrc = PCSRC_ALUOUT;
        o_ctrl.branch = 1'b1;
      end
      S_ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: o_ctrl.regwrite = 1'b1;
      S_JUMP: begin
        o_ctrl.pcsrc = PCSRC_JUMP;
        o_ctrl.pcwrite = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore FSM sequencing the shared multicycle MIPS datapath
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input logic clk,
  input logic reset,
  mips_multicycle_control_if.master bus
);
  state_t r_state;
  state_t w_next;
  ctrl_t w_ctrl;
  logic w_pcwrite;
  // State register; reset aborts any instruction and returns to FETCH at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else r_state <= w_next;
  end
  // Next state: memory states hold until mem_ready, DECODE dispatches on opcode
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next = (bus.opcode == OPW'(OP_LW) || bus.opcode == OPW'(OP_SW)) ? S_MEMADR :
                         bus.opcode == OPW'(OP_RTYPE) ? S_RTYPEEX :
                         bus.opcode == OPW'(OP_BEQ) ? S_BRANCH :
                         bus.opcode == OPW'(OP_ADDI) ? S_ADDIEX :
                         bus.opcode == OPW'(OP_J) ? S_JUMP : S_FETCH;
      S_MEMADR: w_next = bus.opcode == OPW'(OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default: w_next = S_FETCH;
    endcase
  end
  mips_ctrl_outdec u_outdec (
    .i_state(r_state),
    .o_ctrl(w_ctrl)
  );
  // The fetch-time PC load waits for memory; the jump-time load does not
  assign w_pcwrite = w_ctrl.pcwrite & (bus.mem_ready | ~w_ctrl.irwrite);
  assign bus.iord = w_ctrl.iord;
  assign bus.alusrca = w_ctrl.alusrca;
  assign bus.alusrcb = w_ctrl.alusrcb;
  assign bus.regdst = w_ctrl.regdst;
  assign bus.memtoreg = w_ctrl.memtoreg;
  assign bus.pcsrc = w_ctrl.pcsrc;
  assign bus.aluop = w_ctrl.aluop;
  assign bus.irwrite = w_ctrl.irwrite & bus.mem_ready & ~reset;
  assign bus.memread = w_ctrl.memread & ~reset;
  assign bus.memwrite = w_ctrl.memwrite & ~reset;
  assign bus.regwrite = w_ctrl.regwrite & ~reset;
  assign bus.pcen = (w_pcwrite | (w_ctrl.branch & bus.zero)) & ~reset;
  assign bus.state_dbg = STW'(r_state);
endmodule
